// File: rtl/seq_edge_pkg.sv
// Shared types and defaults for the edge-event dispatcher.
package seq_edge_pkg;
    localparam int N_DEF = 8;
    localparam int IDX_W = $clog2(N_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/seq_edge_rr_pick.sv
// Round-robin pick: lowest set index at or above i_ptr, wrapping to the lowest
// set index below it.
module seq_edge_rr_pick
    import seq_edge_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    input  logic [PW-1:0] i_ptr,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    logic [PW-1:0] w_pos;

    // Scan offsets from high to low so the smallest offset from i_ptr wins.
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = i_ptr + PW'(k);
            if (i_vec[w_pos]) begin
                o_idx = w_pos;
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seq_edge_event_dispatch.sv
// Drains a sticky edge-capture vector into a pending set and dispatches one
// event index per val/rdy handshake in round-robin order.
module seq_edge_event_dispatch
    import seq_edge_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         capt,
    output logic                 capt_clear,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
    output logic [$clog2(N)-1:0] ostream_idx,
    output logic                 busy,
    output logic [CNT_W-1:0]     disp_count
);
    localparam int PW = $clog2(N);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_pending;
    logic [N-1:0]     w_pending_nxt;
    logic [N-1:0]     w_fire_mask;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_idx;
    logic [PW-1:0]    w_pick_ptr;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_fire;
    logic             w_load_idx;
    logic [CNT_W-1:0] r_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_fire        = ostream_val && ostream_rdy;
    assign w_fire_mask   = w_fire ? (N'(1) << r_idx) : '0;
    assign w_pending_nxt = (r_pending & ~w_fire_mask) | capt;

    // In IDLE the pending set is empty, so w_pending_nxt equals capt.
    assign w_pick_ptr = (r_state == IDLE) ? r_ptr : r_idx + PW'(1);
    assign w_load_idx = (r_state == IDLE) ? (|capt) : (w_fire && w_pick_any);

    seq_edge_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .i_vec (w_pending_nxt),
        .i_ptr (w_pick_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign capt_clear = reset_n && (|capt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|capt) w_state_nxt = DRAIN;
            DRAIN:   if (w_fire && !w_pick_any) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ostream_val = (r_state == DRAIN);
        busy        = (r_state == DRAIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_fire) begin
                r_ptr   <= r_idx + PW'(1);
                r_count <= sat_inc(r_count);
            end
            if (w_load_idx) begin
                r_idx <= w_pick_idx;
            end
        end
    end

    assign ostream_idx = r_idx;
    assign disp_count  = r_count;
endmodule

// File: tb/tb_seq_edge_event_dispatch.sv
// Bench for seq_edge_event_dispatch: directed scenarios plus a randomized run
// against a set-based round-robin reference model.
module tb_seq_edge_event_dispatch;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  capt;
    logic        rdy;
    logic        capt_clear;
    logic        ostream_val;
    logic [2:0]  ostream_idx;
    logic        busy;
    logic [15:0] disp_count;

    logic [7:0]  capt_s;
    logic        rdy_s;
    logic        capt_clear_s;
    logic        val_s;
    logic [2:0]  idx_s;
    logic        busy_s;
    logic [1:0]  count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_edge_event_dispatch #(.N(8), .CNT_W(16)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .capt        (capt),
        .capt_clear  (capt_clear),
        .ostream_val (ostream_val),
        .ostream_rdy (rdy),
        .ostream_idx (ostream_idx),
        .busy        (busy),
        .disp_count  (disp_count)
    );

    seq_edge_event_dispatch #(.N(8), .CNT_W(2)) u_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .capt        (capt_s),
        .capt_clear  (capt_clear_s),
        .ostream_val (val_s),
        .ostream_rdy (rdy_s),
        .ostream_idx (idx_s),
        .busy        (busy_s),
        .disp_count  (count_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_model(input bit [7:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; capt = 8'hFF; rdy = 1'b0; capt_s = 8'h00; rdy_s = 1'b0;
        #12;
        checks++; if (capt_clear !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b want 0", capt_clear); end
        checks++; if (ostream_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b want 0", ostream_val); end
        checks++; if (ostream_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", ostream_idx); end
        checks++; if (disp_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", disp_count); end
        capt = 8'h00;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        capt = 8'b0000_0101; rdy = 1'b1; #1;
        checks++; if (capt_clear !== 1'b1) begin errors++; $display("FAIL basic_clear: got %b want 1", capt_clear); end
        checks++; if (ostream_val !== 1'b0) begin errors++; $display("FAIL basic_val_t: got %b want 0", ostream_val); end
        step();
        capt = 8'h00; #1;
        checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'd0) begin errors++; $display("FAIL basic_t1: got val=%b idx=%0d want val=1 idx=0", ostream_val, ostream_idx); end
        step(); #1;
        checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'd2) begin errors++; $display("FAIL basic_t2: got val=%b idx=%0d want val=1 idx=2", ostream_val, ostream_idx); end
        step(); #1;
        checks++; if (ostream_val !== 1'b0) begin errors++; $display("FAIL basic_t3_val: got %b want 0", ostream_val); end
        checks++; if (disp_count !== 16'd2) begin errors++; $display("FAIL basic_count: got %0d want 2", disp_count); end
    endtask

    task automatic test_stall();
        capt = 8'h80; rdy = 1'b0; #1;
        step();
        capt = 8'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'd7) begin errors++; $display("FAIL stall_hold%0d: got val=%b idx=%0d want val=1 idx=7", k, ostream_val, ostream_idx); end
            step();
        end
        rdy = 1'b1; #1;
        step(); #1;
        checks++; if (ostream_val !== 1'b0) begin errors++; $display("FAIL stall_after_val: got %b want 0", ostream_val); end
        checks++; if (disp_count !== 16'd3) begin errors++; $display("FAIL stall_count: got %0d want 3", disp_count); end
    endtask

    task automatic test_wrap();
        int exp_order[3] = '{6, 0, 1};
        capt = 8'h20; rdy = 1'b1; #1;
        step();
        capt = 8'h00; #1;
        checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'd5) begin errors++; $display("FAIL wrap_pre: got val=%b idx=%0d want val=1 idx=5", ostream_val, ostream_idx); end
        step();
        capt = 8'b0100_0011; #1;
        step();
        capt = 8'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'(exp_order[k])) begin errors++; $display("FAIL wrap_order%0d: got val=%b idx=%0d want val=1 idx=%0d", k, ostream_val, ostream_idx, exp_order[k]); end
            step();
        end
        #1;
        checks++; if (ostream_val !== 1'b0 || disp_count !== 16'd7) begin errors++; $display("FAIL wrap_end: got val=%b count=%0d want val=0 count=7", ostream_val, disp_count); end
    endtask

    task automatic test_coalesce();
        int exp_order[3] = '{1, 3, 4};
        capt = 8'h01; rdy = 1'b1; #1;
        step();
        capt = 8'h00;
        step();
        capt = 8'b0000_1010; rdy = 1'b0; #1;
        step();
        capt = 8'h00; #1;
        checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'd1) begin errors++; $display("FAIL merge_stall: got val=%b idx=%0d want val=1 idx=1", ostream_val, ostream_idx); end
        step();
        capt = 8'b0001_1000; #1;
        checks++; if (capt_clear !== 1'b1 || ostream_idx !== 3'd1) begin errors++; $display("FAIL merge_absorb: got clear=%b idx=%0d want clear=1 idx=1", capt_clear, ostream_idx); end
        step();
        capt = 8'h00; rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'(exp_order[k])) begin errors++; $display("FAIL merge_order%0d: got val=%b idx=%0d want val=1 idx=%0d", k, ostream_val, ostream_idx, exp_order[k]); end
            step();
        end
        #1;
        checks++; if (ostream_val !== 1'b0 || disp_count !== 16'd11) begin errors++; $display("FAIL merge_end: got val=%b count=%0d want val=0 count=11", ostream_val, disp_count); end
    endtask

    task automatic test_reset_mid();
        capt = 8'h07; rdy = 1'b0; #1;
        step();
        capt = 8'h00; #1;
        checks++; if (ostream_val !== 1'b1 || ostream_idx !== 3'd0) begin errors++; $display("FAIL rmid_pre: got val=%b idx=%0d want val=1 idx=0", ostream_val, ostream_idx); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (ostream_val !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_drop: got val=%b busy=%b want 0 0", ostream_val, busy); end
        checks++; if (disp_count !== 16'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", disp_count); end
        step();
        reset_n = 1'b1; rdy = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ostream_val !== 1'b0 || disp_count !== 16'd0) begin errors++; $display("FAIL rmid_idle%0d: got val=%b count=%0d want 0 0", k, ostream_val, disp_count); end
            step();
        end
    endtask

    task automatic test_saturation();
        capt_s = 8'h1F; rdy_s = 1'b1; #1;
        step();
        capt_s = 8'h00;
        for (int k = 0; k < 6; k++) step();
        #1;
        checks++; if (count_s !== 2'd3) begin errors++; $display("FAIL sat_count: got %0d want 3", count_s); end
        checks++; if (val_s !== 1'b0) begin errors++; $display("FAIL sat_val: got %b want 0", val_s); end
    endtask

    task automatic test_random();
        bit [7:0] m_pend;
        int       m_ptr;
        int       m_cur;
        bit       m_has;
        int       m_count;
        bit       fire;
        capt = 8'h00; rdy = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        m_pend = '0; m_ptr = 0; m_cur = -1; m_has = 1'b0; m_count = 0;
        for (int c = 0; c < 400; c++) begin
            capt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rdy  = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (capt_clear !== (|capt)) begin errors++; $display("FAIL rnd_clear c%0d: got %b want %b", c, capt_clear, |capt); end
            checks++; if (ostream_val !== m_has) begin errors++; $display("FAIL rnd_val c%0d: got %b want %b", c, ostream_val, m_has); end
            if (m_has) begin
                checks++; if (ostream_idx !== 3'(m_cur)) begin errors++; $display("FAIL rnd_idx c%0d: got %0d want %0d", c, ostream_idx, m_cur); end
            end
            checks++; if (disp_count !== 16'(m_count)) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, disp_count, m_count); end
            fire = m_has && rdy;
            if (fire) begin
                m_pend[m_cur] = 1'b0;
                m_count++;
                m_ptr = (m_cur + 1) % N;
            end
            m_pend = m_pend | capt;
            if (!m_has || fire) begin
                m_cur = rr_model(m_pend, m_ptr);
                m_has = (m_cur >= 0);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_coalesce();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
